// File: rtl/text_render_pipe.sv
// Text-mode pixel pipeline: pixel address -> character cell -> VRAM -> font ROM -> 12-bit colour.
// Optional cursor blink is built when the CURSOR_BLINK_EN macro is defined.
module text_render_pipe #(
    parameter int unsigned COLS      = 70,
    parameter int unsigned ROWS      = 30,
    parameter int unsigned CHAR_W    = 9,
    parameter int unsigned CHAR_H    = 16,
    parameter int unsigned BLINK_DIV = 25000000,
    parameter logic [11:0] FG        = 12'hFFF,
    parameter logic [11:0] BG        = 12'h000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pix_valid,
    input  logic [9:0]        h_addr,
    input  logic [9:0]        v_addr,
    input  logic              roll_step,
    input  logic              roll_clear,
    input  logic [6:0]        cursor_col,
    input  logic [4:0]        cursor_row,
    output logic [11:0]       vram_addr,
    input  logic [7:0]        vram_data,
    output logic [11:0]       font_addr,
    input  logic [CHAR_W-1:0] font_data,
    output logic [11:0]       rgb,
    output logic              rgb_valid,
    output logic [4:0]        roll_base
);

    localparam int unsigned OFFX_W = $clog2(CHAR_W);
    localparam int unsigned OFFY_W = $clog2(CHAR_H);
    localparam int unsigned AREA_W = COLS * CHAR_W;
    localparam int unsigned AREA_H = ROWS * CHAR_H;
    localparam int unsigned DEPTH  = 4;

    // Elaboration-time guard on the geometry the address path can hold
    if (COLS * ROWS > 4096 || BLINK_DIV < 1) begin : g_param_check
        $error("text_render_pipe: COLS*ROWS must be <= 4096 and BLINK_DIV >= 1");
    end

    logic              w_frame_start;
    logic [4:0]        w_base;
    logic [9:0]        w_col;
    logic [9:0]        w_row;
    logic [9:0]        w_phys;
    logic [9:0]        w_phys_adj;
    logic [OFFX_W-1:0] w_offx;
    logic [OFFY_W-1:0] w_offy;
    logic              w_in_area;
    logic              w_cursor_hit;
    logic [11:0]       w_vram_addr;
    logic              w_cursor_inv;
    logic              w_pix;
    logic [11:0]       w_rgb;

    logic [4:0]        r_pending;
    logic              r_valid   [1:DEPTH];
    logic [OFFX_W-1:0] r_offx    [1:DEPTH];
    logic              r_in_area [1:DEPTH];
    logic              r_cur     [1:DEPTH];
    logic [OFFY_W-1:0] r_offy1;
    logic [OFFY_W-1:0] r_offy2;

    // S1 address decode; the first pixel of a frame already uses the newly latched roll
    always_comb begin
        w_frame_start = pix_valid && (h_addr == 10'd0) && (v_addr == 10'd0);
        w_base        = w_frame_start ? r_pending : roll_base;
        w_col         = h_addr / 10'(CHAR_W);
        w_offx        = OFFX_W'(h_addr % 10'(CHAR_W));
        w_row         = v_addr / 10'(CHAR_H);
        w_offy        = OFFY_W'(v_addr % 10'(CHAR_H));
        w_in_area     = (32'(h_addr) < AREA_W) && (32'(v_addr) < AREA_H);
        w_cursor_hit  = (w_col == 10'(cursor_col)) && (w_row == 10'(cursor_row));
        w_phys        = w_row + 10'(w_base);
        w_phys_adj    = (w_phys >= 10'(ROWS)) ? (w_phys - 10'(ROWS)) : w_phys;
        w_vram_addr   = 12'(32'(w_phys_adj) * COLS + 32'(w_col));
    end

`ifdef CURSOR_BLINK_EN
    logic [24:0] r_blink_cnt;
    logic        r_blink_phase;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_blink_cnt   <= 25'd0;
            r_blink_phase <= 1'b1;
        end else if (r_blink_cnt == 25'(BLINK_DIV - 1)) begin
            r_blink_cnt   <= 25'd0;
            r_blink_phase <= ~r_blink_phase;
        end else begin
            r_blink_cnt   <= r_blink_cnt + 25'd1;
        end
    end

    assign w_cursor_inv = r_cur[DEPTH] && r_blink_phase;
`else
    assign w_cursor_inv = r_cur[DEPTH];
`endif

    // S5 colour select
    always_comb begin
        w_pix = font_data[r_offx[DEPTH]] ^ w_cursor_inv;
        w_rgb = BG;
        if (r_valid[DEPTH] && r_in_area[DEPTH]) begin
            w_rgb = w_pix ? FG : BG;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 1; i <= int'(DEPTH); i++) begin
                r_valid[i]   <= 1'b0;
                r_offx[i]    <= '0;
                r_in_area[i] <= 1'b0;
                r_cur[i]     <= 1'b0;
            end
            r_offy1   <= '0;
            r_offy2   <= '0;
            vram_addr <= 12'd0;
            font_addr <= 12'd0;
            rgb       <= BG;
            rgb_valid <= 1'b0;
        end else begin
            r_valid[1]   <= pix_valid;
            r_offx[1]    <= w_offx;
            r_in_area[1] <= w_in_area;
            r_cur[1]     <= w_cursor_hit;
            for (int i = 2; i <= int'(DEPTH); i++) begin
                r_valid[i]   <= r_valid[i-1];
                r_offx[i]    <= r_offx[i-1];
                r_in_area[i] <= r_in_area[i-1];
                r_cur[i]     <= r_cur[i-1];
            end
            r_offy1   <= w_offy;
            r_offy2   <= r_offy1;
            vram_addr <= w_vram_addr;
            font_addr <= 12'({vram_data, r_offy2});
            rgb       <= w_rgb;
            rgb_valid <= r_valid[DEPTH];
        end
    end

    // Pending roll accumulates freely; it only reaches the display at frame start
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending <= 5'd0;
            roll_base <= 5'd0;
        end else begin
            if (roll_clear) begin
                r_pending <= 5'd0;
            end else if (roll_step) begin
                r_pending <= (r_pending == 5'(ROWS - 1)) ? 5'd0 : (r_pending + 5'd1);
            end
            if (w_frame_start) begin
                roll_base <= r_pending;
            end
        end
    end

endmodule

// File: tb/tb_text_render_pipe.sv
// Directed bench for text_render_pipe with synchronous VRAM and font ROM models.
module tb_text_render_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        pix_valid;
    logic [9:0]  h_addr;
    logic [9:0]  v_addr;
    logic        roll_step;
    logic        roll_clear;
    logic [6:0]  cursor_col;
    logic [4:0]  cursor_row;
    logic [11:0] vram_addr;
    logic [7:0]  vram_data;
    logic [11:0] font_addr;
    logic [8:0]  font_data;
    logic [11:0] rgb;
    logic        rgb_valid;
    logic [4:0]  roll_base;

    logic [7:0] vram [0:4095];
    logic [8:0] font [0:4095];

    int tests = 0;
    int fails = 0;

    text_render_pipe dut (
        .clk        (clk),
        .reset      (reset),
        .pix_valid  (pix_valid),
        .h_addr     (h_addr),
        .v_addr     (v_addr),
        .roll_step  (roll_step),
        .roll_clear (roll_clear),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row),
        .vram_addr  (vram_addr),
        .vram_data  (vram_data),
        .font_addr  (font_addr),
        .font_data  (font_data),
        .rgb        (rgb),
        .rgb_valid  (rgb_valid),
        .roll_base  (roll_base)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        vram_data <= vram[vram_addr];
        font_data <= font[font_addr];
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // One pixel through the pipe, capturing each stage at its fixed latency
    task automatic pix(input logic vld_in, input logic [9:0] h, input logic [9:0] y,
                       output logic [11:0] va, output logic [11:0] fa,
                       output logic vld4, output logic [11:0] c, output logic vld5);
        pix_valid = vld_in;
        h_addr    = h;
        v_addr    = y;
        tick(1);
        va        = vram_addr;
        pix_valid = 1'b0;
        tick(2);
        fa        = font_addr;
        tick(1);
        vld4      = rgb_valid;
        tick(1);
        c         = rgb;
        vld5      = rgb_valid;
    endtask

    task automatic steps(input int n);
        roll_step = 1'b1;
        tick(n);
        roll_step = 1'b0;
    endtask

    logic [11:0] va, fa, c;
    logic        v4, v5;

    initial begin
        for (int i = 0; i < 4096; i++) begin
            vram[i] = 8'h00;
            font[i] = 9'h000;
        end
        vram[0]     = 8'h41;
        vram[142]   = 8'h42;
        vram[72]    = 8'h43;
        font[12'h410] = 9'h001;
        font[12'h423] = 9'h001;
        font[12'h430] = 9'h001;
        font[12'h004] = 9'h1FF;
        font[12'h000] = 9'h1FF;

        reset = 1'b1; pix_valid = 1'b0; h_addr = '0; v_addr = '0;
        roll_step = 1'b0; roll_clear = 1'b0; cursor_col = 7'd69; cursor_row = 5'd29;
        tick(2);
        chk("reset_rgb", 32'(rgb), 32'h000);
        chk("reset_rgb_valid", 32'(rgb_valid), 32'd0);
        chk("reset_vram_addr", 32'(vram_addr), 32'd0);
        chk("reset_font_addr", 32'(font_addr), 32'd0);
        chk("reset_roll_base", 32'(roll_base), 32'd0);
        reset = 1'b0;
        tick(1);

        // Origin pixel: 'A' at cell 0
        pix(1'b1, 10'd0, 10'd0, va, fa, v4, c, v5);
        chk("t1_vram_addr", 32'(va), 32'd0);
        chk("t1_font_addr", 32'(fa), 32'h410);
        chk("t1_rgb", 32'(c), 32'hFFF);

        // Cell (2,2), offY 3: exact latency of 5
        pix(1'b1, 10'd18, 10'd35, va, fa, v4, c, v5);
        chk("t2_vram_addr", 32'(va), 32'd142);
        chk("t2_font_addr", 32'(fa), 32'h423);
        chk("t2_valid_t4", 32'(v4), 32'd0);
        chk("t2_rgb", 32'(c), 32'hFFF);
        chk("t2_valid_t5", 32'(v5), 32'd1);
        tick(1);
        chk("t2_valid_t6", 32'(rgb_valid), 32'd0);
        pix(1'b1, 10'd19, 10'd35, va, fa, v4, c, v5);
        chk("t2_off1_rgb", 32'(c), 32'h000);
        chk("t2_off1_valid", 32'(v5), 32'd1);

        // Out of area and invalid samples
        pix(1'b1, 10'd635, 10'd100, va, fa, v4, c, v5);
        chk("t3_oob_font_addr", 32'(fa), 32'h004);
        chk("t3_oob_h_rgb", 32'(c), 32'h000);
        chk("t3_oob_h_valid", 32'(v5), 32'd1);
        pix(1'b1, 10'd18, 10'd480, va, fa, v4, c, v5);
        chk("t3_oob_v_rgb", 32'(c), 32'h000);
        pix(1'b0, 10'd18, 10'd35, va, fa, v4, c, v5);
        chk("t3_novalid_rgb", 32'(c), 32'h000);
        chk("t3_novalid_valid", 32'(v5), 32'd0);

        // Roll held back until frame start
        steps(3);
        chk("t4_base_pending", 32'(roll_base), 32'd0);
        pix(1'b1, 10'd18, 10'd35, va, fa, v4, c, v5);
        chk("t4_mid_vram_addr", 32'(va), 32'd142);
        chk("t4_mid_base", 32'(roll_base), 32'd0);
        pix(1'b1, 10'd0, 10'd0, va, fa, v4, c, v5);
        chk("t4_fs_vram_addr", 32'(va), 32'd210);
        chk("t4_fs_base", 32'(roll_base), 32'd3);
        pix(1'b1, 10'd18, 10'd448, va, fa, v4, c, v5);
        chk("t4_row28_vram_addr", 32'(va), 32'd72);
        chk("t4_row28_rgb", 32'(c), 32'hFFF);

        // Pending wrap and clear priority
        steps(2);
        pix(1'b1, 10'd0, 10'd0, va, fa, v4, c, v5);
        chk("t5_base5", 32'(roll_base), 32'd5);
        roll_step = 1'b1; roll_clear = 1'b1;
        tick(1);
        roll_step = 1'b0; roll_clear = 1'b0;
        pix(1'b1, 10'd0, 10'd0, va, fa, v4, c, v5);
        chk("t5_clear_wins", 32'(roll_base), 32'd0);
        steps(29);
        pix(1'b1, 10'd0, 10'd0, va, fa, v4, c, v5);
        chk("t5_base29", 32'(roll_base), 32'd29);
        chk("t5_base29_vram_addr", 32'(va), 32'd2030);
        steps(1);
        pix(1'b1, 10'd0, 10'd0, va, fa, v4, c, v5);
        chk("t5_wrap", 32'(roll_base), 32'd0);

        // Cursor inversion at logical (2,2)
        cursor_col = 7'd2; cursor_row = 5'd2;
        pix(1'b1, 10'd19, 10'd35, va, fa, v4, c, v5);
        chk("t6_cursor_bg_inv", 32'(c), 32'hFFF);
        pix(1'b1, 10'd18, 10'd35, va, fa, v4, c, v5);
        chk("t6_cursor_fg_inv", 32'(c), 32'h000);
        cursor_col = 7'd69; cursor_row = 5'd29;

        // Mid-frame reset flushes pipe and roll
        steps(3);
        pix(1'b1, 10'd0, 10'd0, va, fa, v4, c, v5);
        chk("t7_pre_base", 32'(roll_base), 32'd3);
        pix_valid = 1'b1; h_addr = 10'd18; v_addr = 10'd35;
        tick(1);
        pix_valid = 1'b0;
        tick(1);
        reset = 1'b1;
        tick(1);
        chk("t7_rst_vram_addr", 32'(vram_addr), 32'd0);
        chk("t7_rst_font_addr", 32'(font_addr), 32'd0);
        chk("t7_rst_rgb", 32'(rgb), 32'h000);
        chk("t7_rst_base", 32'(roll_base), 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("t7_flushed_valid", 32'(rgb_valid), 32'd0);
            tick(1);
        end
        pix(1'b1, 10'd0, 10'd0, va, fa, v4, c, v5);
        chk("t7_pending_cleared", 32'(roll_base), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
